elevator_call_scheduler: RTL and testbench

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

---
 rtl/elevator_call_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Purpose : latches car/hall button requests and picks the next target floor
//           for a single elevator car using a collective (up/down sweep) policy.
// Latency : press -> pend_* at edge 1; pend/state -> next_floor/target_valid/dir at edge 2.
// Backpr. : none; buttons are sampled every cycle and requests stay latched until served.
// Ports   : clk, reset (async, active-high)
//           btn_num_in/btn_up_out/btn_down_out : per-floor car and hall buttons
//           current_floor, serve               : car position and door-open strobe
//           next_floor, target_valid, dir      : registered target for motion control
//           pend_in/pend_up/pend_down          : latched requests (button lamps)
module elevator_call_scheduler #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_num_in,
  input  logic [FLOORS-1:0]  btn_up_out,
  input  logic [FLOORS-1:0]  btn_down_out,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               serve,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               target_valid,
  output logic [1:0]         dir,
  output logic [FLOORS-1:0]  pend_in,
  output logic [FLOORS-1:0]  pend_up,
  output logic [FLOORS-1:0]  pend_down
);

  // Encoding doubles as the dir output value.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_UP   = 2'd2
  } state_t;

  // No up-call exists on the top floor and no down-call on the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  state_t             state_q, state_d;
  logic [FLOORS-1:0]  pend_in_q, pend_in_d;
  logic [FLOORS-1:0]  pend_up_q, pend_up_d;
  logic [FLOORS-1:0]  pend_dn_q, pend_dn_d;
  logic [FLOOR_W-1:0] next_floor_q, next_floor_d;
  logic               target_valid_q, target_valid_d;
  logic [1:0]         dir_q, dir_d;

  logic [FLOORS-1:0]  clr_in, clr_up, clr_dn;
  logic [FLOORS-1:0]  any_req, up_pref, dn_pref;
  int                 cur;

  // Search results, all relative to current_floor.
  logic               abv_pref_v, abv_any_v, abv_near_v;
  logic [FLOOR_W-1:0] abv_pref_f, abv_any_f, abv_near_f;
  logic               blw_pref_v, blw_any_v, blw_near_v;
  logic [FLOOR_W-1:0] blw_pref_f, blw_any_f, blw_near_f;
  logic               any_le, any_ge;
  logic               at_in, at_up, at_dn;

  // Pending request latches; a serve clear beats a same-cycle press.
  always_comb begin
    clr_in = '0;
    clr_up = '0;
    clr_dn = '0;
    if (serve) begin
      clr_in[current_floor] = 1'b1;
      if (state_q != ST_DOWN) clr_up[current_floor] = 1'b1;
      if (state_q != ST_UP)   clr_dn[current_floor] = 1'b1;
    end
    pend_in_d = (pend_in_q | btn_num_in) & ~clr_in;
    pend_up_d = (pend_up_q | (btn_up_out & UP_MASK)) & ~clr_up;
    pend_dn_d = (pend_dn_q | (btn_down_out & DN_MASK)) & ~clr_dn;
  end

  // Floor searches over the registered request bits. Ascending loops keep the
  // highest match, descending loops keep the lowest match.
  always_comb begin
    cur        = int'(current_floor);
    any_req    = pend_in_q | pend_up_q | pend_dn_q;
    up_pref    = pend_in_q | pend_up_q;
    dn_pref    = pend_in_q | pend_dn_q;
    abv_pref_v = 1'b0; abv_pref_f = '0;
    abv_any_v  = 1'b0; abv_any_f  = '0;
    abv_near_v = 1'b0; abv_near_f = '0;
    blw_pref_v = 1'b0; blw_pref_f = '0;
    blw_any_v  = 1'b0; blw_any_f  = '0;
    blw_near_v = 1'b0; blw_near_f = '0;
    any_le     = 1'b0;
    any_ge     = 1'b0;
    at_in      = pend_in_q[current_floor];
    at_up      = pend_up_q[current_floor];
    at_dn      = pend_dn_q[current_floor];
    for (int f = 0; f < FLOORS; f++) begin
      if (f > cur && any_req[f]) begin abv_any_v  = 1'b1; abv_any_f  = FLOOR_W'(f); end
      if (f < cur && dn_pref[f]) begin blw_pref_v = 1'b1; blw_pref_f = FLOOR_W'(f); end
      if (f < cur && any_req[f]) begin blw_near_v = 1'b1; blw_near_f = FLOOR_W'(f); end
      if (f <= cur && any_req[f]) any_le = 1'b1;
      if (f >= cur && any_req[f]) any_ge = 1'b1;
    end
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (f > cur && up_pref[f]) begin abv_pref_v = 1'b1; abv_pref_f = FLOOR_W'(f); end
      if (f > cur && any_req[f]) begin abv_near_v = 1'b1; abv_near_f = FLOOR_W'(f); end
      if (f < cur && any_req[f]) begin blw_any_v  = 1'b1; blw_any_f  = FLOOR_W'(f); end
    end
  end

  // Next-state and target selection.
  always_comb begin
    state_d        = state_q;
    next_floor_d   = next_floor_q;
    target_valid_d = 1'b0;
    case (state_q)
      ST_UP: begin
        target_valid_d = 1'b1;
        if (abv_pref_v)          next_floor_d = abv_pref_f;
        else if (abv_any_v)      next_floor_d = abv_any_f;
        else if (at_in || at_up) next_floor_d = current_floor;
        else if (any_le) begin
          // Reverse: a down-call here is served first, otherwise head below.
          state_d = ST_DOWN;
          if (at_dn)           next_floor_d = current_floor;
          else if (blw_pref_v) next_floor_d = blw_pref_f;
          else                 next_floor_d = blw_any_f;
        end else begin
          state_d        = ST_IDLE;
          target_valid_d = 1'b0;
        end
      end
      ST_DOWN: begin
        target_valid_d = 1'b1;
        if (blw_pref_v)          next_floor_d = blw_pref_f;
        else if (blw_any_v)      next_floor_d = blw_any_f;
        else if (at_in || at_dn) next_floor_d = current_floor;
        else if (any_ge) begin
          state_d = ST_UP;
          if (at_up)           next_floor_d = current_floor;
          else if (abv_pref_v) next_floor_d = abv_pref_f;
          else                 next_floor_d = abv_any_f;
        end else begin
          state_d        = ST_IDLE;
          target_valid_d = 1'b0;
        end
      end
      default: begin
        if (|any_req) begin
          target_valid_d = 1'b1;
          if (at_in || at_up || at_dn) begin
            next_floor_d = current_floor;
          end else if (abv_near_v &&
                       (!blw_near_v ||
                        (int'(abv_near_f) - cur) <= (cur - int'(blw_near_f)))) begin
            // Equal distance resolves upward.
            state_d      = ST_UP;
            next_floor_d = abv_near_f;
          end else begin
            state_d      = ST_DOWN;
            next_floor_d = blw_near_f;
          end
        end
      end
    endcase
    dir_d = state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pend_in_q      <= '0;
      pend_up_q      <= '0;
      pend_dn_q      <= '0;
      next_floor_q   <= '0;
      target_valid_q <= 1'b0;
      dir_q          <= 2'd0;
    end else begin
      state_q        <= state_d;
      pend_in_q      <= pend_in_d;
      pend_up_q      <= pend_up_d;
      pend_dn_q      <= pend_dn_d;
      next_floor_q   <= next_floor_d;
      target_valid_q <= target_valid_d;
      dir_q          <= dir_d;
    end
  end

  assign next_floor   = next_floor_q;
  assign target_valid = target_valid_q;
  assign dir          = dir_q;
  assign pend_in      = pend_in_q;
  assign pend_up      = pend_up_q;
  assign pend_down    = pend_dn_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn_num_in = '0;
  logic [7:0] btn_up_out = '0;
  logic [7:0] btn_down_out = '0;
  logic [2:0] current_floor = '0;
  logic       serve = 1'b0;
  logic [2:0] next_floor;
  logic       target_valid;
  logic [1:0] dir;
  logic [7:0] pend_in, pend_up, pend_down;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  elevator_call_scheduler #(.FLOORS(8), .FLOOR_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_num_in(btn_num_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .current_floor(current_floor), .serve(serve),
    .next_floor(next_floor), .target_valid(target_valid), .dir(dir),
    .pend_in(pend_in), .pend_up(pend_up), .pend_down(pend_down)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] floor);
    reset         = 1'b1;
    btn_num_in    = '0;
    btn_up_out    = '0;
    btn_down_out  = '0;
    serve         = 1'b0;
    current_floor = floor;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({next_floor, target_valid, dir, pend_in, pend_up, pend_down} !== 30'd0)
      $display("FAIL reset_async: got nf=%0d v=%0d dir=%0d pin=%h pup=%h pdn=%h, want all 0",
               next_floor, target_valid, dir, pend_in, pend_up, pend_down);
    else pass_cnt++;
    do_reset(3'd0);
    chk_cnt++;
    if ({next_floor, target_valid, dir, pend_in, pend_up, pend_down} !== 30'd0)
      $display("FAIL reset_release: got nf=%0d v=%0d dir=%0d, want all 0", next_floor, target_valid, dir);
    else pass_cnt++;
  endtask

  task automatic test_first_press();
    do_reset(3'd0);
    btn_num_in = 8'b0010_0000;
    cycle();
    btn_num_in = '0;
    chk_cnt++;
    if (pend_in !== 8'h20 || target_valid !== 1'b0)
      $display("FAIL press_edge1: pend_in=%h v=%0d, want 20 v=0", pend_in, target_valid);
    else pass_cnt++;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd5 || dir !== 2'd2 || target_valid !== 1'b1)
      $display("FAIL press_edge2: nf=%0d dir=%0d v=%0d, want 5 2 1", next_floor, dir, target_valid);
    else pass_cnt++;
  endtask

  task automatic test_up_sweep();
    do_reset(3'd2);
    btn_num_in = 8'h40;
    cycle();
    btn_num_in = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd6 || dir !== 2'd2)
      $display("FAIL up_first: nf=%0d dir=%0d, want 6 2", next_floor, dir);
    else pass_cnt++;
    btn_up_out = 8'h10;
    cycle();
    btn_up_out = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd4 || dir !== 2'd2)
      $display("FAIL up_intermediate: nf=%0d dir=%0d, want 4 2", next_floor, dir);
    else pass_cnt++;
    current_floor = 3'd4;
    serve = 1'b1;
    cycle();
    serve = 1'b0;
    chk_cnt++;
    if (pend_up !== 8'h00 || pend_in !== 8'h40)
      $display("FAIL up_serve_clear: pend_up=%h pend_in=%h, want 00 40", pend_up, pend_in);
    else pass_cnt++;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd6 || dir !== 2'd2 || target_valid !== 1'b1)
      $display("FAIL up_continue: nf=%0d dir=%0d v=%0d, want 6 2 1", next_floor, dir, target_valid);
    else pass_cnt++;
  endtask

  task automatic test_reversal();
    do_reset(3'd3);
    btn_down_out = 8'h40;
    cycle();
    btn_down_out = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd6 || dir !== 2'd2)
      $display("FAIL rev_target: nf=%0d dir=%0d, want 6 2", next_floor, dir);
    else pass_cnt++;
    current_floor = 3'd6;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd6 || dir !== 2'd1)
      $display("FAIL rev_turn: nf=%0d dir=%0d, want 6 1", next_floor, dir);
    else pass_cnt++;
    serve = 1'b1;
    cycle();
    serve = 1'b0;
    chk_cnt++;
    if (pend_down !== 8'h00)
      $display("FAIL rev_serve_clear: pend_down=%h, want 00", pend_down);
    else pass_cnt++;
    cycle();
    chk_cnt++;
    if (dir !== 2'd0 || target_valid !== 1'b0 || next_floor !== 3'd6)
      $display("FAIL rev_idle_hold: dir=%0d v=%0d nf=%0d, want 0 0 6", dir, target_valid, next_floor);
    else pass_cnt++;
  endtask

  task automatic test_idle_tie();
    do_reset(3'd4);
    btn_up_out   = 8'h04;
    btn_down_out = 8'h40;
    cycle();
    btn_up_out   = '0;
    btn_down_out = '0;
    chk_cnt++;
    if (pend_up !== 8'h04 || pend_down !== 8'h40)
      $display("FAIL tie_latch: pend_up=%h pend_down=%h, want 04 40", pend_up, pend_down);
    else pass_cnt++;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd6 || dir !== 2'd2)
      $display("FAIL tie_up: nf=%0d dir=%0d, want 6 2", next_floor, dir);
    else pass_cnt++;
  endtask

  task automatic test_idle_at_floor();
    do_reset(3'd5);
    btn_num_in = 8'h20;
    cycle();
    btn_num_in = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd5 || dir !== 2'd0 || target_valid !== 1'b1)
      $display("FAIL idle_here: nf=%0d dir=%0d v=%0d, want 5 0 1", next_floor, dir, target_valid);
    else pass_cnt++;
    serve = 1'b1;
    cycle();
    serve = 1'b0;
    cycle();
    chk_cnt++;
    if (pend_in !== 8'h00 || target_valid !== 1'b0)
      $display("FAIL idle_here_served: pend_in=%h v=%0d, want 00 0", pend_in, target_valid);
    else pass_cnt++;
  endtask

  task automatic test_down_sweep();
    do_reset(3'd6);
    btn_num_in = 8'h01;
    cycle();
    btn_num_in = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd0 || dir !== 2'd1)
      $display("FAIL down_first: nf=%0d dir=%0d, want 0 1", next_floor, dir);
    else pass_cnt++;
    btn_up_out = 8'h08;
    cycle();
    btn_up_out = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd0 || dir !== 2'd1)
      $display("FAIL down_skip_upcall: nf=%0d dir=%0d, want 0 1", next_floor, dir);
    else pass_cnt++;
    btn_down_out = 8'h04;
    cycle();
    btn_down_out = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd2 || dir !== 2'd1)
      $display("FAIL down_pick_downcall: nf=%0d dir=%0d, want 2 1", next_floor, dir);
    else pass_cnt++;
  endtask

  task automatic test_clear_wins();
    do_reset(3'd3);
    serve      = 1'b1;
    btn_num_in = 8'h08;
    cycle();
    serve      = 1'b0;
    btn_num_in = '0;
    chk_cnt++;
    if (pend_in !== 8'h00)
      $display("FAIL clear_wins: pend_in=%h, want 00", pend_in);
    else pass_cnt++;
    btn_up_out   = 8'h80;
    btn_down_out = 8'h01;
    cycle();
    cycle();
    btn_up_out   = '0;
    btn_down_out = '0;
    chk_cnt++;
    if (pend_up !== 8'h00 || pend_down !== 8'h00 || target_valid !== 1'b0)
      $display("FAIL edge_calls_ignored: pend_up=%h pend_down=%h v=%0d, want 00 00 0",
               pend_up, pend_down, target_valid);
    else pass_cnt++;
    // Held button re-latches the cycle after the serve clear.
    btn_num_in = 8'h08;
    serve      = 1'b1;
    cycle();
    serve = 1'b0;
    chk_cnt++;
    if (pend_in !== 8'h00)
      $display("FAIL held_clear: pend_in=%h, want 00", pend_in);
    else pass_cnt++;
    cycle();
    btn_num_in = '0;
    chk_cnt++;
    if (pend_in !== 8'h08)
      $display("FAIL held_reset_bit: pend_in=%h, want 08", pend_in);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_travel();
    do_reset(3'd4);
    btn_num_in = 8'h04;
    cycle();
    btn_num_in = 8'hFF;
    cycle();
    btn_num_in = '0;
    cycle();
    chk_cnt++;
    if (pend_in !== 8'hFF || dir !== 2'd1)
      $display("FAIL mid_setup: pend_in=%h dir=%0d, want FF 1", pend_in, dir);
    else pass_cnt++;
    reset = 1'b1;
    #2;
    chk_cnt++;
    if ({next_floor, target_valid, dir, pend_in, pend_up, pend_down} !== 30'd0)
      $display("FAIL mid_async: nf=%0d v=%0d dir=%0d pin=%h, want all 0",
               next_floor, target_valid, dir, pend_in);
    else pass_cnt++;
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    cycle();
    chk_cnt++;
    if ({next_floor, target_valid, dir, pend_in, pend_up, pend_down} !== 30'd0)
      $display("FAIL mid_after: nf=%0d v=%0d dir=%0d pin=%h, want all 0",
               next_floor, target_valid, dir, pend_in);
    else pass_cnt++;
    btn_num_in = 8'h01;
    cycle();
    btn_num_in = '0;
    cycle();
    chk_cnt++;
    if (next_floor !== 3'd0 || dir !== 2'd1 || target_valid !== 1'b1)
      $display("FAIL mid_resume: nf=%0d dir=%0d v=%0d, want 0 1 1", next_floor, dir, target_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_up_sweep();
    test_reversal();
    test_idle_tie();
    test_idle_at_floor();
    test_down_sweep();
    test_clear_wins();
    test_reset_mid_travel();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
